// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package bus_arb_pkg;

  localparam int         MAX_REQ   = 8;
  localparam logic [3:0] SIZE_WORD = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } e_arb_state;

endpackage

// File: rtl/bus_arb_if.sv
// Memory-side port of the arbiter: one muxed access channel.
// Handshake: an access (read or write high) is accepted in exactly the cycle
// where ready is also high; until then the arbiter holds addr/wr_data/size/
// read/write stable. Read data for an accepted read arrives on rd_data in the
// following cycle.
interface bus_arb_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  size;
  logic        read;
  logic        write;
  logic        ready;
  logic [31:0] rd_data;

  modport master (
    output addr, wr_data, size, read, write,
    input  ready, rd_data
  );

  modport slave (
    input  addr, wr_data, size, read, write,
    output ready, rd_data
  );
endinterface

// File: rtl/bus_arb_pick.sv
// Combinational rotating priority picker: first set cand bit at or after start.
module bus_arb_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // start_i is always < N, so one wrap subtraction is enough
  function automatic int wrap_pos(input int s, input int k);
    int j;
    j = s + k;
    if (j >= N) j = j - N;
    return j;
  endfunction

  logic found;

  // scan N positions starting at start_i, keep the first hit
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && cand_i[wrap_pos(int'(start_i), k)]) begin
        found                                 = 1'b1;
        onehot_o[wrap_pos(int'(start_i), k)] = 1'b1;
        idx_o                                 = IDX_W'(wrap_pos(int'(start_i), k));
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Memory bus arbiter: pends requests, issues one registered grant at a time,
// muxes the winner onto the memory port and routes read data back.
// Macro BUS_ARB_RR_EN selects round-robin; otherwise fixed priority (index 0 wins).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0][31:0] wr_data_i,
  input  logic [NUM_REQ-1:0][3:0]  size_i,
  input  logic [NUM_REQ-1:0]      read_i,
  input  logic [NUM_REQ-1:0]      write_i,
  output logic [31:0]             rd_data_o,
  output logic [NUM_REQ-1:0]      rvalid_o,
  bus_arb_if.master               mem,
  output logic [CNT_W-1:0]        abandon_cnt_o,
  output e_arb_state              state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  e_arb_state         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rd_data_q;

  logic [NUM_REQ-1:0] cand, pick_oh;
  logic [IDX_W-1:0]   pick_idx, start;
  logic               pick_vld;
  logic               wr_sel, rd_sel, acc;

  // the current winner's own req is ignored while it holds the grant
  assign cand = (req_i | pend_q) & ~gnt_q;

`ifdef BUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d;

  function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] w);
    if (int'(w) == NUM_REQ - 1) return '0;
    return w + 1'b1;
  endfunction

  // a back-to-back grant must already search from the post-transfer pointer
  assign start = (state_q == GRANT) ? nxt_idx(win_q) : rr_q;

  // round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  assign start = '0;
`endif

  bus_arb_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .cand_i   (cand),
    .start_i  (start),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  // winner mux onto the memory port; write wins over read
  always_comb begin
    wr_sel        = 1'b0;
    rd_sel        = 1'b0;
    mem.addr      = '0;
    mem.wr_data   = '0;
    mem.size      = '0;
    if (state_q == GRANT) begin
      wr_sel      = write_i[win_q];
      rd_sel      = read_i[win_q] & ~write_i[win_q];
      mem.addr    = addr_i[win_q];
      mem.wr_data = wr_data_i[win_q];
      mem.size    = size_i[win_q];
    end
    mem.read  = rd_sel;
    mem.write = wr_sel;
    acc       = wr_sel | rd_sel;
  end

  // next-state, grant, pending, read-return and abandon-count logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    win_d    = win_q;
    pend_d   = cand;
    cnt_d    = cnt_q;
    rvalid_d = '0;
`ifdef BUS_ARB_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          pend_d  = cand & ~pick_oh;
        end
      end
      GRANT: begin
        if (acc && mem.ready) begin
          if (rd_sel) rvalid_d = gnt_q;
`ifdef BUS_ARB_RR_EN
          rr_d = nxt_idx(win_q);
`endif
          if (pick_vld) begin
            gnt_d  = pick_oh;
            win_d  = pick_idx;
            pend_d = cand & ~pick_oh;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!acc) begin
          state_d = IDLE;
          gnt_d   = '0;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
`ifdef BUS_ARB_RR_EN
          rr_d = nxt_idx(win_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      rvalid_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rd_data_q <= rd_data_o;
    end
  end

  // read data passes through in the return cycle and is held afterwards
  assign rd_data_o     = (|rvalid_q) ? mem.rd_data : rd_data_q;
  assign rvalid_o      = rvalid_q;
  assign gnt_o         = gnt_q;
  assign abandon_cnt_o = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (both BUS_ARB_RR_EN builds).
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 8;
`ifdef BUS_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0][31:0] addr_i;
  logic [NUM_REQ-1:0][31:0] wr_data_i;
  logic [NUM_REQ-1:0][3:0]  size_i;
  logic [NUM_REQ-1:0]       read_i;
  logic [NUM_REQ-1:0]       write_i;
  logic [31:0]              rd_data_o;
  logic [NUM_REQ-1:0]       rvalid_o;
  logic [CNT_W-1:0]         abandon_cnt_o;
  e_arb_state               state_o;

  bus_arb_if mem_if ();

  bus_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .size_i        (size_i),
    .read_i        (read_i),
    .write_i       (write_i),
    .rd_data_o     (rd_data_o),
    .rvalid_o      (rvalid_o),
    .mem           (mem_if),
    .abandon_cnt_o (abandon_cnt_o),
    .state_o       (state_o)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          acc_cnt  = 0;
  int          acc_snap;
  int          exp_cnt;

  // counts accepted memory writes
  always @(posedge clk_i) begin
    if (mem_if.write && mem_if.ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    req_i          = '0;
    read_i         = '0;
    write_i        = '0;
    addr_i         = '0;
    wr_data_i      = '0;
    size_i         = '0;
    mem_if.ready   = 1'b0;
    mem_if.rd_data = '0;
  endtask

  // one-cycle write by requester idx, completes immediately
  task automatic single_write(input int idx);
    @(negedge clk_i);
    clear_inputs();
    req_i[idx] = 1'b1;
    @(negedge clk_i);
    req_i          = '0;
    write_i[idx]   = 1'b1;
    mem_if.ready   = 1'b1;
    #1 check_eq("single_gnt", 32'(gnt_o), 32'(1 << idx));
    @(negedge clk_i);
    clear_inputs();
    #1 check_eq("single_drop", 32'(gnt_o), 32'h0);
  endtask

  // both requesters request together and both write with ready high
  task automatic contention(input string tag, input logic [1:0] first, input logic [1:0] second);
    @(negedge clk_i);
    clear_inputs();
    req_i = 2'b11;
    #1 check_eq({tag, "_idle"}, 32'(gnt_o), 32'h0);
    @(negedge clk_i);
    req_i        = '0;
    write_i      = 2'b11;
    wr_data_i[0] = 32'hA000_0000;
    wr_data_i[1] = 32'hB000_0001;
    mem_if.ready = 1'b1;
    #1 check_eq({tag, "_first"}, 32'(gnt_o), 32'(first));
    check_eq({tag, "_first_data"}, mem_if.wr_data, (first == 2'b01) ? 32'hA000_0000 : 32'hB000_0001);
    @(negedge clk_i);
    #1 check_eq({tag, "_second"}, 32'(gnt_o), 32'(second));
    check_eq({tag, "_second_data"}, mem_if.wr_data, (second == 2'b01) ? 32'hA000_0000 : 32'hB000_0001);
    @(negedge clk_i);
    clear_inputs();
    #1 check_eq({tag, "_done"}, 32'(gnt_o), 32'h0);
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_eq("rst_gnt", 32'(gnt_o), 32'h0);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
    check_eq("rst_rd_data", rd_data_o, 32'h0);
    check_eq("rst_cnt", 32'(abandon_cnt_o), 32'h0);
    check_eq("rst_state", 32'(state_o), 32'(IDLE));
    check_eq("rst_mem_addr", mem_if.addr, 32'h0);
    check_eq("rst_mem_wdata", mem_if.wr_data, 32'h0);
    check_eq("rst_mem_size", 32'(mem_if.size), 32'h0);
    check_eq("rst_mem_rw", {30'h0, mem_if.read, mem_if.write}, 32'h0);

    // single write from requester 1
    @(negedge clk_i);
    req_i = 2'b10;
    #1 check_eq("wr_gnt_c0", 32'(gnt_o), 32'h0);
    @(negedge clk_i);
    req_i        = '0;
    addr_i[1]    = 32'h0000_0100;
    wr_data_i[1] = 32'hDEAD_BEEF;
    size_i[1]    = SIZE_WORD;
    write_i[1]   = 1'b1;
    mem_if.ready = 1'b1;
    #1 check_eq("wr_gnt_c1", 32'(gnt_o), 32'h2);
    check_eq("wr_mem_addr", mem_if.addr, 32'h0000_0100);
    check_eq("wr_mem_wdata", mem_if.wr_data, 32'hDEAD_BEEF);
    check_eq("wr_mem_size", 32'(mem_if.size), 32'hF);
    check_eq("wr_mem_write", 32'(mem_if.write), 32'h1);
    check_eq("wr_mem_read", 32'(mem_if.read), 32'h0);
    @(negedge clk_i);
    clear_inputs();
    #1 check_eq("wr_gnt_c2", 32'(gnt_o), 32'h0);
    check_eq("wr_mem_write_c2", 32'(mem_if.write), 32'h0);

    // read from requester 0
    @(negedge clk_i);
    req_i = 2'b01;
    @(negedge clk_i);
    req_i        = '0;
    read_i[0]    = 1'b1;
    addr_i[0]    = 32'h0000_0040;
    mem_if.ready = 1'b1;
    exp_q.push_back(32'h1234_5678);
    #1 check_eq("rd_gnt_c1", 32'(gnt_o), 32'h1);
    check_eq("rd_mem_read", 32'(mem_if.read), 32'h1);
    check_eq("rd_mem_addr", mem_if.addr, 32'h0000_0040);
    check_eq("rd_rvalid_c1", 32'(rvalid_o), 32'h0);
    @(negedge clk_i);
    clear_inputs();
    mem_if.rd_data = 32'h1234_5678;
    #1 check_eq("rd_rvalid_c2", 32'(rvalid_o), 32'h1);
    check_eq("rd_data_c2", rd_data_o, exp_q.pop_front());
    @(negedge clk_i);
    mem_if.rd_data = 32'hA5A5_0000;
    #1 check_eq("rd_rvalid_c3", 32'(rvalid_o), 32'h0);
    check_eq("rd_data_hold", rd_data_o, 32'h1234_5678);

    // contention: RR pointer is 1 after the read by requester 0
    contention("cont_a", RR_EN ? 2'b10 : 2'b01, RR_EN ? 2'b01 : 2'b10);
    // requester 1 transfer moves the RR pointer back to 0
    single_write(1);
    contention("cont_b", 2'b01, 2'b10);

    // stall: write by 0 with ready low for 3 cycles, requester 1 pended
    @(negedge clk_i);
    clear_inputs();
    req_i = 2'b01;
    @(negedge clk_i);
    req_i        = 2'b10;
    write_i[0]   = 1'b1;
    wr_data_i[0] = 32'h5555_AAAA;
    mem_if.ready = 1'b0;
    acc_snap     = acc_cnt;
    #1 check_eq("stall_gnt_1", 32'(gnt_o), 32'h1);
    @(negedge clk_i);
    req_i     = '0;
    read_i[0] = 1'b1;
    #1 check_eq("stall_gnt_2", 32'(gnt_o), 32'h1);
    check_eq("stall_pend", 32'(dut.pend_q), 32'h2);
    check_eq("stall_rd_masked", 32'(mem_if.read), 32'h0);
    check_eq("stall_wr_held", 32'(mem_if.write), 32'h1);
    @(negedge clk_i);
    #1 check_eq("stall_gnt_3", 32'(gnt_o), 32'h1);
    @(negedge clk_i);
    mem_if.ready = 1'b1;
    #1 check_eq("stall_gnt_4", 32'(gnt_o), 32'h1);
    @(negedge clk_i);
    write_i = 2'b10;
    read_i  = '0;
    #1 check_eq("stall_next_gnt", 32'(gnt_o), 32'h2);
    check_eq("stall_accepts", 32'(acc_cnt - acc_snap), 32'h1);
    check_eq("stall_pend_clr", 32'(dut.pend_q), 32'h0);
    @(negedge clk_i);
    clear_inputs();
    #1 check_eq("stall_done", 32'(gnt_o), 32'h0);
    check_eq("cnt_before_abandon", 32'(abandon_cnt_o), 32'h0);

    // abandon 300 times: counter saturates
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      clear_inputs();
      req_i = 2'b01;
      #1 check_eq("abandon_drop", 32'(gnt_o), 32'h0);
      check_eq("abandon_cnt", 32'(abandon_cnt_o), 32'(exp_cnt));
      @(negedge clk_i);
      req_i = '0;
      #1 check_eq("abandon_gnt", 32'(gnt_o), 32'h1);
      if (exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk_i);
    #1 check_eq("abandon_final_drop", 32'(gnt_o), 32'h0);
    check_eq("abandon_sat", 32'(abandon_cnt_o), 32'hFF);

    // reset in the middle of a stalled grant
    @(negedge clk_i);
    clear_inputs();
    req_i = 2'b10;
    @(negedge clk_i);
    req_i        = 2'b01;
    write_i[1]   = 1'b1;
    mem_if.ready = 1'b0;
    #1 check_eq("rstmid_gnt", 32'(gnt_o), 32'h2);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_inputs();
    req_i = 2'b01;
    #1 check_eq("rstmid_gnt_clr", 32'(gnt_o), 32'h0);
    check_eq("rstmid_pend", 32'(dut.pend_q), 32'h0);
    check_eq("rstmid_cnt", 32'(abandon_cnt_o), 32'h0);
    check_eq("rstmid_state", 32'(state_o), 32'(IDLE));
    @(negedge clk_i);
    req_i        = '0;
    write_i[0]   = 1'b1;
    mem_if.ready = 1'b1;
    #1 check_eq("rstmid_regrant", 32'(gnt_o), 32'h1);
    @(negedge clk_i);
    clear_inputs();
    #1 check_eq("rstmid_done", 32'(gnt_o), 32'h0);
    check_eq("rstmid_cnt_after", 32'(abandon_cnt_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
